// File: rtl/acc_job_if.sv
// Requester/consumer bundle of the shared accumulator scheduler.
// master = requester front-ends plus result consumer, slave = scheduler.
`timescale 1ns/1ps
interface acc_job_if #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4,
    parameter int D_W   = 4,
    parameter int ACC_W = 8,
    parameter int ID_W  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic                  s_valid;
    logic [D_W-1:0]        s_data;
    logic                  s_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [ACC_W-1:0]      res_data;
    logic [ID_W-1:0]       res_id;
    logic                  res_ovf;
    logic                  busy;

    modport master (
        output req, len, s_valid, s_data, res_ready,
        input  gnt, s_ready, res_valid, res_data, res_id, res_ovf, busy
    );

    modport slave (
        input  req, len, s_valid, s_data, res_ready,
        output gnt, s_ready, res_valid, res_data, res_id, res_ovf, busy
    );
endinterface

// File: rtl/acc_job_scheduler.sv
// Round-robin scheduler running one summation job at a time on a private
// accumulator: grant, clear, accept len samples, hold the result until taken.
`timescale 1ns/1ps
module acc_job_scheduler #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4,
    parameter int D_W   = 4,
    parameter int ACC_W = 8,
    parameter int ID_W  = $clog2(NREQ)
) (
    input logic      clk,
    input logic      reset,
    acc_job_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        ACCUM  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [ID_W-1:0]  ptr_r;
    logic [ID_W-1:0]  id_r;
    logic [LEN_W-1:0] cnt_r;
    logic [ACC_W-1:0] acc_r;
    logic             ovf_r;

    logic [ID_W-1:0]  win_s;
    logic [ID_W-1:0]  idx_s;
    logic             any_req_s;
    logic             hit_s;
    logic [LEN_W-1:0] len_sel_s;
    logic [NREQ-1:0]  gnt_s;
    logic             sready_s;
    logic             rvalid_s;
    logic             busy_s;
    logic             accept_s;
    logic             carry_s;
    logic [ACC_W-1:0] sum_s;

    // Round-robin pick: first requesting index at or after ptr_r, wrapping
    always_comb begin
        win_s     = {ID_W{1'b0}};
        idx_s     = {ID_W{1'b0}};
        hit_s     = 1'b0;
        any_req_s = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx_s     = ID_W'((int'(ptr_r) + off) % NREQ);
            hit_s     = bus.req[idx_s] && !any_req_s;
            win_s     = hit_s ? idx_s : win_s;
            any_req_s = any_req_s | hit_s;
        end
    end

    // Length field of the arbitration winner
    always_comb begin
        len_sel_s = {LEN_W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            len_sel_s = (win_s == ID_W'(i)) ? bus.len[i*LEN_W +: LEN_W] : len_sel_s;
        end
    end

    // Carry-out of the widened add is the overflow indication
    assign {carry_s, sum_s} = {1'b0, acc_r} + {{(ACC_W - D_W + 1){1'b0}}, bus.s_data};
    assign accept_s = bus.s_valid && sready_s;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) state_s = CLEAR;
                else           state_s = IDLE;
            end
            CLEAR: begin
                if (cnt_r == {LEN_W{1'b0}}) state_s = RESULT;
                else                        state_s = ACCUM;
            end
            ACCUM: begin
                if (accept_s && (cnt_r == LEN_W'(1'b1))) state_s = RESULT;
                else                                     state_s = ACCUM;
            end
            RESULT: begin
                if (bus.res_ready) state_s = IDLE;
                else               state_s = RESULT;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode, purely from the state register
    always_comb begin
        gnt_s    = {NREQ{1'b0}};
        sready_s = 1'b0;
        rvalid_s = 1'b0;
        busy_s   = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
            end
            CLEAR: begin
                gnt_s  = NREQ'(1'b1) << id_r;
                busy_s = 1'b1;
            end
            ACCUM: begin
                gnt_s    = NREQ'(1'b1) << id_r;
                sready_s = 1'b1;
                busy_s   = 1'b1;
            end
            RESULT: begin
                rvalid_s = 1'b1;
                busy_s   = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Job datapath: latch winner, clear, accumulate, advance pointer on hand-off
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= {ID_W{1'b0}};
            id_r  <= {ID_W{1'b0}};
            cnt_r <= {LEN_W{1'b0}};
            acc_r <= {ACC_W{1'b0}};
            ovf_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        id_r  <= win_s;
                        cnt_r <= len_sel_s;
                    end
                end
                CLEAR: begin
                    acc_r <= {ACC_W{1'b0}};
                    ovf_r <= 1'b0;
                end
                ACCUM: begin
                    if (accept_s) begin
                        acc_r <= sum_s;
                        ovf_r <= ovf_r | carry_s;
                        cnt_r <= cnt_r - LEN_W'(1'b1);
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        ptr_r <= (id_r == ID_W'(NREQ - 1)) ? {ID_W{1'b0}} : id_r + ID_W'(1'b1);
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_s;
    assign bus.s_ready   = sready_s;
    assign bus.res_valid = rvalid_s;
    assign bus.res_data  = acc_r;
    assign bus.res_id    = id_r;
    assign bus.res_ovf   = ovf_r;
    assign bus.busy      = busy_s;
endmodule

// File: tb/tb_acc_job_scheduler.sv
// Scoreboard bench for acc_job_scheduler: randomized jobs against a
// round-robin/summation reference model, plus directed timing corners.
`timescale 1ns/1ps
module tb_acc_job_scheduler;
    localparam int NREQ  = 4;
    localparam int LEN_W = 4;
    localparam int D_W   = 4;
    localparam int ACC_W = 8;
    localparam int ID_W  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    acc_job_if #(.NREQ(NREQ), .LEN_W(LEN_W), .D_W(D_W), .ACC_W(ACC_W), .ID_W(ID_W)) bus ();
    acc_job_if #(.NREQ(NREQ), .LEN_W(LEN_W), .D_W(D_W), .ACC_W(6), .ID_W(ID_W)) bus6 ();

    acc_job_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W), .D_W(D_W), .ACC_W(ACC_W), .ID_W(ID_W))
        u_dut (.clk(clk), .reset(reset), .bus(bus));
    acc_job_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W), .D_W(D_W), .ACC_W(6), .ID_W(ID_W))
        u_dut6 (.clk(clk), .reset(reset), .bus(bus6));

    typedef struct { int id; int data; int ovf; } res_t;
    typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;

    res_t exp_q[$];
    chk_t chk_q[$];
    int   idle_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   srdy_cyc = 0;
    int   idle_run = 0;
    bit   idle_track = 1'b0;
    int   ptr_m = 0;
    int   smp[16];

    always @(posedge clk) cyc <= cyc + 1;

    // Checker: the only process that compares and counts
    initial begin : monitor
        chk_t c;
        res_t e;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                compare(c.name, c.act, c.exp);
            end
            if (reset && bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    compare("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    compare("res_id", 32'(bus.res_id), 32'(e.id));
                    compare("res_data", 32'(bus.res_data), 32'(e.data));
                    compare("res_ovf", 32'(bus.res_ovf), 32'(e.ovf));
                end
            end
        end
    end

    // Activity watcher: grant/ready cycle counts and idle gaps between jobs
    initial begin : watcher
        forever begin
            @(negedge clk);
            if (bus.gnt != '0) gnt_cyc++;
            if (bus.s_ready) srdy_cyc++;
            if (!bus.busy) begin
                idle_run++;
            end else begin
                if (idle_track && idle_run > 0) idle_q.push_back(idle_run);
                idle_run = 0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_q.push_back('{name: nm, act: act, exp: exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_winner(input logic [3:0] rq);
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (ptr_m + k) % NREQ;
            if (((int'(rq) >> j) % 2) == 1) return j;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_data"}, 32'(bus.res_data), 32'd0);
        chk({tag, "_res_id"}, 32'(bus.res_id), 32'd0);
        chk({tag, "_res_ovf"}, 32'(bus.res_ovf), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // One job end to end; samples come from smp[], vprob < 0 selects the 1,0,0,1,1 valid pattern
    task automatic run_job(input logic [3:0] rq, input logic [15:0] ln, input int vprob,
                           input int hold, input int rprob, input bit drop,
                           output int g_edge, output int r_edge);
        int w, L, sum, idx, step, guard, t0;
        bit acc_b, done;
        logic [31:0] d0;
        logic [4:0] pat;
        pat = 5'b11001;
        w   = model_winner(rq);
        L   = (int'(ln) >> (LEN_W * w)) % 16;
        sum = 0;
        for (int i = 0; i < L; i++) sum += smp[i];
        exp_q.push_back('{id: w, data: sum % (1 << ACC_W), ovf: (sum >= (1 << ACC_W)) ? 1 : 0});

        bus.req = rq;
        bus.len = ln;
        t0 = cyc;
        guard = 0;
        while (bus.gnt == '0 && guard < 20) begin
            tick();
            guard++;
        end
        g_edge = cyc - t0;
        chk("grant", 32'(bus.gnt), 32'(1 << w));
        if (drop) bus.req = '0;

        idx = 0; step = 0; guard = 0;
        while (idx < L && guard < 400) begin
            if (vprob < 0) bus.s_valid = pat[step % 5];
            else bus.s_valid = (int'($urandom_range(0, 99)) < vprob);
            bus.s_data = 4'(smp[idx]);
            acc_b = bus.s_valid && bus.s_ready;
            if (bus.s_ready) step++;
            tick();
            guard++;
            if (acc_b) idx++;
        end
        bus.s_valid = 1'b0;
        chk("samples_accepted", 32'(idx), 32'(L));

        guard = 0;
        while (!bus.res_valid && guard < 20) begin
            tick();
            guard++;
        end
        r_edge = cyc - t0;
        chk("res_valid_seen", 32'(bus.res_valid), 32'd1);

        d0 = 32'(bus.res_data);
        for (int k = 0; k < hold; k++) begin
            bus.res_ready = 1'b0;
            chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_res_data", 32'(bus.res_data), d0);
            chk("hold_gnt", 32'(bus.gnt), 32'd0);
            tick();
        end

        done = 1'b0; guard = 0;
        while (!done && guard < 60) begin
            bus.res_ready = (int'($urandom_range(0, 99)) < rprob);
            done = bus.res_ready && bus.res_valid;
            tick();
            guard++;
        end
        bus.res_ready = 1'b0;
        chk("result_accepted", 32'(done), 32'd1);
        ptr_m = (w + 1) % NREQ;
    endtask

    initial begin : main
        int g, r, g0, s0, na, guard, sum6;
        bus.req = '0; bus.len = '0; bus.s_valid = 1'b0; bus.s_data = '0; bus.res_ready = 1'b0;
        bus6.req = '0; bus6.len = '0; bus6.s_valid = 1'b0; bus6.s_data = '0; bus6.res_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Single job 5+7+2
        smp[0] = 5; smp[1] = 7; smp[2] = 2;
        g0 = gnt_cyc;
        run_job(4'b0001, 16'h0003, 100, 0, 100, 1'b1, g, r);
        chk("single_gnt_cycles", 32'(gnt_cyc - g0), 32'd4);
        chk("single_grant_edge", 32'(g), 32'd1);
        chk("single_result_edge", 32'(r), 32'd5);

        // Fifteen 15s fit in 8 bits; a fresh job must start from a cleared accumulator
        for (int i = 0; i < 16; i++) smp[i] = 15;
        run_job(4'b0010, 16'h00F0, 100, 0, 100, 1'b1, g, r);
        run_job(4'b0010, 16'h0020, 100, 0, 100, 1'b1, g, r);

        // Valid pattern 1,0,0,1,1 on a three-sample job
        smp[0] = 4; smp[1] = 9; smp[2] = 6;
        run_job(4'b0100, 16'h0300, -1, 0, 100, 1'b1, g, r);
        chk("bp_result_edge", 32'(r), 32'd7);

        // Result held 10 cycles with the requester still asserting
        smp[0] = 11; smp[1] = 8;
        run_job(4'b0001, 16'h0002, 100, 10, 100, 1'b0, g, r);
        bus.req = '0;

        // Zero-length job
        s0 = srdy_cyc;
        run_job(4'b0100, 16'h0000, 100, 0, 100, 1'b1, g, r);
        chk("zero_s_ready_cycles", 32'(srdy_cyc - s0), 32'd0);
        chk("zero_result_edge", 32'(r), 32'd2);

        // Randomized jobs
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < 16; i++) smp[i] = int'($urandom_range(0, 15));
            run_job(4'($urandom_range(1, 15)), 16'($urandom), int'($urandom_range(30, 100)),
                    0, int'($urandom_range(30, 100)), 1'b1, g, r);
            repeat (int'($urandom_range(0, 2))) tick();
        end

        // Reset in the middle of a four-sample job
        bus.req = 4'b1000; bus.len = 16'h4000; bus.s_valid = 1'b1; bus.s_data = 4'd3;
        na = 0; guard = 0;
        while (na < 2 && guard < 30) begin
            if (bus.s_valid && bus.s_ready) na++;
            tick();
            guard++;
        end
        chk("rst_mid_two_accepts", 32'(na), 32'd2);
        bus.req = '0; bus.s_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        ptr_m = 0;
        tick(); tick();
        reset = 1'b1;

        // Round robin: all requesting, len 1, sample = id + 1, one idle cycle between jobs
        for (int j = 0; j < 5; j++) begin
            smp[0] = model_winner(4'hF) + 1;
            run_job(4'hF, 16'h1111, 100, 0, 100, 1'b0, g, r);
            if (j == 0) chk("post_reset_grant_edge", 32'(g), 32'd1);
            idle_track = (j < 4);
        end
        bus.req = '0;
        tick();
        chk("rr_idle_gaps", 32'(idle_q.size()), 32'd4);
        foreach (idle_q[i]) chk("rr_idle_gap_len", 32'(idle_q[i]), 32'd1);

        // Narrow accumulator: fifteen 15s wrap a 6-bit register
        sum6 = 0;
        for (int i = 0; i < 15; i++) sum6 += 15;
        bus6.req = 4'b0001; bus6.len = 16'h000F; bus6.s_valid = 1'b1; bus6.s_data = 4'd15;
        guard = 0;
        while (!bus6.res_valid && guard < 40) begin
            tick();
            guard++;
        end
        chk("w6_res_valid", 32'(bus6.res_valid), 32'd1);
        chk("w6_res_data", 32'(bus6.res_data), 32'(sum6 % 64));
        chk("w6_res_ovf", 32'(bus6.res_ovf), 32'((sum6 >= 64) ? 1 : 0));
        chk("w6_res_id", 32'(bus6.res_id), 32'd0);
        bus6.req = '0; bus6.s_valid = 1'b0; bus6.res_ready = 1'b1;
        tick();
        bus6.res_ready = 1'b0;

        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/acc_job_scheduler.md
# acc_job_scheduler

Shares one 8-bit accumulator between several requesters by running each requester's summation job to completion in round-robin order. A job is one grant, a clear of the accumulator, a fixed number of 4-bit samples accepted over a valid/ready stream, and one held result with requester ID and overflow flag. The block sits between the requester front-ends and the downstream result consumer. The accumulator register is internal, so no requester ever sees partial sums from another job.

## Interface
- NREQ, 4: number of requesters (2..8)
- LEN_W, 4: width of each job-length field
- D_W, 4: sample width
- ACC_W, 8: accumulator width
- ID_W, clog2(NREQ): requester index width
- Clock and reset: reset reset, asynchronous, active-low; clock clk.
- clk  in  1  rising-edge clock
- reset  in  1  async active-low reset
- req  in  NREQ  per-requester job request, level, held until granted
- len  in  NREQ*LEN_W  per-requester sample count; requester i uses bits [i*LEN_W +: LEN_W]
- gnt  out  NREQ  one-hot grant, high for the whole job until RESULT
- s_valid  in  1  sample valid (granted requester's stream, muxed externally)
- s_data  in  D_W  sample value
- s_ready  out  1  sample accepted when s_valid && s_ready
- res_valid  out  1  job result valid, held until accepted
- res_ready  in  1  consumer accepts result
- res_data  out  ACC_W  accumulator value
- res_id  out  ID_W  requester index of the finished job
- res_ovf  out  1  sticky carry-out seen during the job
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, CLEAR, ACCUM, RESULT.
- IDLE:
  - If any req bit is high, pick the first set bit at or after the pointer `ptr`, wrapping around.
  - Latch res_id = winner, cnt = len[winner], then go to CLEAR.
  - If no req bit is high, stay in IDLE.
- CLEAR:
  - gnt[res_id] = 1; acc <= 0; res_ovf <= 0.
  - If cnt == 0, go to RESULT, which gives a result of 0.
  - Otherwise go to ACCUM.
- ACCUM:
  - gnt[res_id] = 1; s_ready = 1.
  - On each accept: acc <= (acc + zero-extended s_data) mod 2^ACC_W; res_ovf <= res_ovf | carry-out; cnt <= cnt - 1.
  - An accept while cnt == 1 moves the FSM to RESULT.
  - If s_valid is low, hold all state with no timeout.
- RESULT:
  - gnt = 0; s_ready = 0; res_valid = 1.
  - res_data, res_id and res_ovf are stable while res_valid is high.
  - On res_ready: ptr <= (res_id + 1) mod NREQ, then go to IDLE.
- res_data is always the acc register. It is meaningful only while res_valid is high.
- req or len changes after the IDLE sampling edge have no effect on the running job.
- A requester dropping req mid-job does not abort the job. The requester must still supply cnt samples.
- s_ready and gnt are driven combinationally from the state register only. They do not depend on s_valid or req.

## Timing
- Reset (asynchronous, any state) forces:
  - state = IDLE, ptr = 0, acc = 0, cnt = 0;
  - gnt = 0, s_ready = 0, res_valid = 0, res_data = 0, res_id = 0, res_ovf = 0, busy = 0.
- Reset mid-job discards the job. The first edge after reset release arbitrates from ptr = 0.
- Request-to-grant latency: req high in IDLE before edge k gives gnt high after edge k (CLEAR state).
- s_ready rises after edge k+1.
- With s_valid held high and len = L ≥ 1:
  - samples are accepted on edges k+2 .. k+L+1;
  - res_valid rises after edge k+L+1.
- With len = 0, res_valid rises after edge k+1.
- Result handshake: an accept on edge m returns the FSM to IDLE after m. The next arbitration happens on edge m+1, giving exactly one idle cycle between jobs.
- Simultaneous res_valid && res_ready in the first RESULT cycle: accepted on that edge.
- Fairness: a requester that holds req waits at most NREQ-1 jobs before being granted.

## Test plan
- Single job: req = 0001, len0 = 3, samples 5, 7, 2 with s_valid held high.
  - Required: gnt = 0001 for 4 cycles; res_valid after 5 edges; res_data = 14, res_id = 0, res_ovf = 0.
- Overflow: len = 15, all samples = 15.
  - Required: res_data = 225 (no wrap).
  - Then len = 15, samples = 15 with a 16th value forced via a second job of len 2 after a first job: verify a fresh clear gives res_data = 30, not 255.
  - Also len = 15 with all samples = 15 is followed by a run of 5 extra 15s in a separate check configuration with ACC_W = 6: required res_ovf = 1 and res_data = 225 mod 64 = 33.
- Round-robin: req = 1111 held, every len = 1, samples = id + 1.
  - Required: results in ID order 0, 1, 2, 3, 0 with res_data 1, 2, 3, 4, 1.
  - Required: exactly one busy-low cycle between consecutive jobs.
- Backpressure:
  - s_valid toggled 1, 0, 0, 1, 1 for len = 3: required that only 3 accepts are counted.
  - res_ready held low for 10 cycles: required res_valid and res_data stable, gnt = 0, and no new grant issued.
- Zero length: len2 = 0, req = 0100.
  - Required: s_ready never high; res_valid after 2 edges with res_data = 0, res_id = 2.
- Reset mid-job: assert reset after the 2nd of 4 samples.
  - Required: all outputs 0 immediately (no clock edge needed).
  - After release with req = 1111: first grant is 0001.
